// File: rtl/vote_tally_tx.sv
// Tally readout transmitter: snapshots four 8-bit tallies and sends HEADER, cand1..cand4 as 8N1 UART bytes.
// Define VOTE_TALLY_CHECKSUM_EN to append an XOR checksum byte to each frame.
module vote_tally_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       report_req,
  input  logic [7:0] cand1_votes,
  input  logic [7:0] cand2_votes,
  input  logic [7:0] cand3_votes,
  input  logic [7:0] cand4_votes,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_MAX = CW'(CLKS_PER_BIT - 1);
`ifdef VOTE_TALLY_CHECKSUM_EN
  localparam logic [2:0]    LAST_BYTE = 3'd5;
`else
  localparam logic [2:0]    LAST_BYTE = 3'd4;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cyc_cnt, cyc_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [2:0]    byte_idx, byte_nx;
  logic [7:0]    snap1, snap2, snap3, snap4;
  logic [7:0]    cur_byte;
  logic          snap_en;
  logic          bit_end;
  logic          fin_q, fin_nx;
  logic          tx_nx, busy_nx;

  assign bit_end = (cyc_cnt == CYC_MAX);

  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd1:    cur_byte = snap1;
      3'd2:    cur_byte = snap2;
      3'd3:    cur_byte = snap3;
      3'd4:    cur_byte = snap4;
`ifdef VOTE_TALLY_CHECKSUM_EN
      3'd5:    cur_byte = snap1 ^ snap2 ^ snap3 ^ snap4;
`endif
      default: cur_byte = HEADER;
    endcase
  end

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc_cnt;
    bit_nx   = bit_cnt;
    byte_nx  = byte_idx;
    snap_en  = 1'b0;
    fin_nx   = 1'b0;
    tx_nx    = 1'b1;
    busy_nx  = 1'b1;
    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (report_req) begin
          snap_en  = 1'b1;
          byte_nx  = '0;
          bit_nx   = '0;
          cyc_nx   = '0;
          state_nx = S_START;
        end
      end
      S_START: begin
        tx_nx = 1'b0;
        if (bit_end) begin
          cyc_nx   = '0;
          bit_nx   = '0;
          state_nx = S_DATA;
        end else begin
          cyc_nx = cyc_cnt + CW'(1);
        end
      end
      S_DATA: begin
        tx_nx = cur_byte[bit_cnt];
        if (bit_end) begin
          cyc_nx = '0;
          if (bit_cnt == 3'd7) begin
            bit_nx   = '0;
            state_nx = S_STOP;
          end else begin
            bit_nx = bit_cnt + 3'd1;
          end
        end else begin
          cyc_nx = cyc_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_nx = '0;
          if (byte_idx == LAST_BYTE) begin
            byte_nx  = '0;
            fin_nx   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            byte_nx  = byte_idx + 3'd1;
            state_nx = S_START;
          end
        end else begin
          cyc_nx = cyc_cnt + CW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by one cycle;
  // fin_q carries frame completion across that lag so done lines up with busy falling.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      snap1    <= '0;
      snap2    <= '0;
      snap3    <= '0;
      snap4    <= '0;
      fin_q    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cyc_cnt  <= cyc_nx;
      bit_cnt  <= bit_nx;
      byte_idx <= byte_nx;
      if (snap_en) begin
        snap1 <= cand1_votes;
        snap2 <= cand2_votes;
        snap3 <= cand3_votes;
        snap4 <= cand4_votes;
      end
      fin_q <= fin_nx;
      tx    <= tx_nx;
      busy  <= busy_nx;
      done  <= fin_q;
    end
  end

endmodule

// File: tb/tb_vote_tally_tx.sv
// Scoreboard bench for vote_tally_tx: expected frames are queued at request time and a UART monitor decodes tx.
module tb_vote_tally_tx;

  localparam int CPB = 4;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef VOTE_TALLY_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int F = NB * 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       report_req = 1'b0;
  logic [7:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic       tx, busy, done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  bit b2b_check = 1'b0;

  logic [7:0] exp_q[$];
  int         len_q[$];

  vote_tally_tx #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
    .clock(clock), .reset(reset), .report_req(report_req),
    .cand1_votes(c1), .cand2_votes(c2), .cand3_votes(c3), .cand4_votes(c4),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: a frame is the header, the four tallies, then optionally their XOR.
  task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(HDR);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
`ifdef VOTE_TALLY_CHECKSUM_EN
    exp_q.push_back(a ^ b ^ c ^ d);
`endif
    len_q.push_back(F);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_done(input int prev, input int bound);
    int n = 0;
    while (done_cnt <= prev && n < bound) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", (done_cnt > prev) ? 1 : 0, 1);
  endtask

  task automatic one_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    int prev;
    prev = done_cnt;
    c1 = a; c2 = b; c3 = c; c4 = d;
    push_frame(a, b, c, d);
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    c1 = 8'($urandom);
    wait_done(prev, F + 50);
    tick(5);
  endtask

  // Monitor: UART decoder plus busy/done framing checks, sampled just after each rising edge.
  bit         dec_active = 1'b0;
  int         dec_t = 0;
  logic [7:0] dec_byte = '0;
  int         busy_len = 0;
  logic       busy_prev = 1'b0;

  always begin
    int k;
    @(posedge clock);
    #1;
    cyc++;
    if (!reset) begin
      if (busy_prev) check("abort_no_done", done, 0);
      dec_active = 1'b0;
      busy_len   = 0;
      busy_prev  = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_at_busy_fall", (busy_prev && !busy) ? 1 : 0, 1);
        if (len_q.size() > 0) check("busy_len", busy_len, len_q.pop_front());
        else check("unexpected_done", 1, 0);
      end else if (busy_prev && !busy) begin
        check("busy_fall_without_done", 0, 1);
      end
      busy_len  = busy ? busy_len + 1 : 0;
      busy_prev = busy;

      if (!dec_active && !tx) begin
        dec_active = 1'b1;
        dec_t = 0;
        if (b2b_check) begin
          check("b2b_gap", cyc - last_done_cyc, 1);
          b2b_check = 1'b0;
        end
      end
      if (dec_active) begin
        if (dec_t % CPB == CPB / 2) begin
          k = dec_t / CPB;
          if (k == 0) check("start_bit", tx, 0);
          else if (k <= 8) dec_byte[k-1] = tx;
          else begin
            check("stop_bit", tx, 1);
            if (exp_q.size() > 0) check("byte", dec_byte, exp_q.pop_front());
            else check("extra_byte", {24'h1, dec_byte}, 0);
            dec_active = 1'b0;
          end
        end
        dec_t++;
      end
    end
  end

  initial begin
    int prev, bad;
    logic [7:0] a, b, c, d;

    // Reset and idle
    tick(3);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_outputs", bad, 0);

    // Basic frame, tally change mid-frame, and a request while busy
    prev = done_cnt;
    c1 = 8'd3; c2 = 8'd5; c3 = 8'd0; c4 = 8'd255;
    push_frame(8'd3, 8'd5, 8'd0, 8'd255);
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    tick(30);
    c1 = 8'h77;
    tick(70);
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    wait_done(prev, F + 50);
    tick(F + 20);
    check("no_extra_frame", done_cnt, prev + 1);

    // Back-to-back frames with report_req held high
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    c1 = a; c2 = b; c3 = c; c4 = d;
    push_frame(a, b, c, d);
    push_frame(a, b, c, d);
    prev = done_cnt;
    report_req = 1'b1;
    wait_done(prev, F + 50);
    b2b_check = 1'b1;
    report_req = 1'b0;
    tick(5);
    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
    wait_done(prev + 1, F + 50);
    check("b2b_checked", b2b_check, 0);
    tick(5);

    // Reset during data bit 3 of the cand2 byte
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    c1 = a; c2 = b; c3 = c; c4 = d;
    exp_q.push_back(HDR);
    exp_q.push_back(a);
    prev = done_cnt;
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    tick(97);
    reset = 1'b0;
    tick(1);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b1;
    tick(10);
    check("abort_no_done_count", done_cnt, prev);
    check("abort_bytes_consumed", exp_q.size(), 0);

    // Full frames after the abort, then randomized frames
    one_frame(8'd1, 8'd2, 8'd3, 8'd4);
    repeat (4) one_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    one_frame(8'hFF, 8'h00, 8'hFF, 8'h00);

    tick(20);
    check("exp_queue_empty", exp_q.size(), 0);
    check("len_queue_empty", len_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vote_tally_tx.md
# vote_tally_tx

Result-readout transmitter for the voting machine: on request it snapshots the four 8-bit candidate tallies and sends them out as a framed 8N1 UART byte stream on a single serial line. It sits beside the vote logger, consuming its four tally outputs, and is the readout end of the tally interface for an external collector. A checksum byte can be compiled in.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per UART bit. Legal range is 2 or more.
- HEADER, default 8'hA5: first byte of every frame.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low. reset==0 at a posedge clears all state.
- report_req  in  1  level, sampled each cycle; starts a frame when the block is idle.
- cand1_votes  in  8  candidate 1 tally.
- cand2_votes  in  8  candidate 2 tally.
- cand3_votes  in  8  candidate 3 tally.
- cand4_votes  in  8  candidate 4 tally.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.

## Operation
- Reset values:
  - tx=1, busy=0, done=0.
  - FSM=IDLE; bit counter, cycle counter and byte index all 0.
- FSM states:
  - IDLE: if report_req=1, snapshot cand1..cand4 into internal registers, set byte index to 0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If this was the last byte, go to IDLE and pulse done; otherwise increment byte index and go to START.
- Frame byte order: HEADER, cand1, cand2, cand3, cand4, then [checksum].
- Byte sizing: the frame is 6 bytes with the checksum, 5 without. There is no idle gap between bytes.
- Snapshot rule: tally inputs are sampled only in the IDLE→START cycle. Input changes during a frame do not affect the frame.
- report_req handling:
  - Ignored while busy=1; it is not queued.
  - If still high on return to IDLE, a new frame starts on the next cycle (back-to-back frames).
- Counter widths: the cycle counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. The byte index is 3 bits.
- Reset mid-frame: on the next edge tx returns to 1, busy=0, and done is not asserted. The partial frame is abandoned.

## Timing
- Start of frame: with report_req=1 sampled at edge N, busy=1 and tx=0 (start bit) from edge N+1.
- Bit k of byte b occupies cycles N+1+(b·10+k)·CLKS_PER_BIT through the next CLKS_PER_BIT−1 cycles. The start bit is k=0, data bits are k=1..8, the stop bit is k=9.
- End of frame:
  - Frame length F = bytes·10·CLKS_PER_BIT cycles.
  - At edge N+1+F: busy=0 and done=1 for exactly one cycle. tx is already 1 (idle).
- Back-to-back frames: if report_req is held high, the next start bit begins at edge N+2+F, i.e. one idle cycle after done.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- VOTE_TALLY_CHECKSUM_EN defined:
  - A 6th byte equal to cand1^cand2^cand3^cand4 (snapshot values) is appended.
  - F = 60·CLKS_PER_BIT.
- VOTE_TALLY_CHECKSUM_EN undefined:
  - The frame ends after cand4 (5 bytes); no checksum logic is present.
  - F = 50·CLKS_PER_BIT.

## Test plan
- Reset and idle:
  - Stimulus: hold reset=0 for 3 cycles, then release with report_req=0 for 50 cycles.
  - Required: tx=1, busy=0 and done=0 throughout.
- Basic frame:
  - Stimulus: CLKS_PER_BIT=4, checksum enabled, tallies 3, 5, 0, 255; pulse report_req for 1 cycle.
  - Required: decoded bytes A5, 03, 05, 00, FF, F9.
  - Required: busy high for exactly 240 cycles; done pulses once, in the cycle busy falls.
- Snapshot stability:
  - Stimulus: during the frame above, change cand1_votes to 8'h77.
  - Required: transmitted cand1 byte is still 03, and the checksum is still F9.
- Request while busy and back-to-back:
  - Stimulus: pulse report_req again mid-frame.
  - Required: no extra frame is sent.
  - Stimulus: hold report_req high.
  - Required: the second frame's start bit begins exactly one idle cycle after done.
- Reset mid-frame:
  - Stimulus: assert reset=0 during data bit 3 of the cand2 byte.
  - Required: tx=1 and busy=0 on the next edge; no done pulse.
  - Stimulus: issue a new request after release.
  - Required: a full, correct frame.
- Checksum disabled:
  - Stimulus: build without VOTE_TALLY_CHECKSUM_EN, tallies 1, 2, 3, 4, CLKS_PER_BIT=4.
  - Required: bytes A5, 01, 02, 03, 04; busy high for exactly 200 cycles.
